// File: rtl/seq_div.sv
// Sequential unsigned restoring divider: one quotient bit per clock, DW+2 cycles per op.
// Optional SEQ_DIV_DBZ_EN adds a dbz flag and a short-cut path for divide by zero.
module seq_div #(
    parameter int unsigned DW = 8,
    parameter int unsigned VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r
`ifdef SEQ_DIV_DBZ_EN
    ,
    output logic          dbz
`endif
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] sreg, sreg_nxt;   // dividend bits shift out the top, quotient bits in the bottom
    logic [VW-1:0] dsor, dsor_nxt;
    logic [VW-1:0] rem, rem_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [VW:0]   prem;
    logic [VW-1:0] diff;
    logic          ge;
    logic          last;
    logic          busy_nxt, done_nxt;
    logic [DW-1:0] q_nxt;
    logic [VW-1:0] r_nxt;
`ifdef SEQ_DIV_DBZ_EN
    logic          dbz_nxt;
`endif

    // One restoring step; the remainder after a subtract is below dsor, so VW bits suffice.
    always_comb begin
        prem = {rem, sreg[DW-1]};
        ge   = (prem >= {1'b0, dsor});
        diff = prem[VW-1:0] - dsor;
        last = (cnt == CW'(DW - 1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CALC;
`ifdef SEQ_DIV_DBZ_EN
                    if (divisor == '0) state_nxt = DONE;
`endif
                end
            end
            CALC:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        sreg_nxt = sreg;
        dsor_nxt = dsor;
        rem_nxt  = rem;
        cnt_nxt  = cnt;
        q_nxt    = q;
        r_nxt    = r;
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
`ifdef SEQ_DIV_DBZ_EN
        dbz_nxt  = dbz;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    sreg_nxt = dividend;
                    dsor_nxt = divisor;
                    rem_nxt  = '0;
                    cnt_nxt  = '0;
`ifdef SEQ_DIV_DBZ_EN
                    if (divisor == '0) begin
                        q_nxt   = '0;
                        r_nxt   = '0;
                        dbz_nxt = 1'b1;
                    end
`endif
                end
            end
            CALC: begin
                rem_nxt  = ge ? diff : prem[VW-1:0];
                sreg_nxt = {sreg[DW-2:0], ge};
                cnt_nxt  = cnt + CW'(1);
                if (last) begin
                    q_nxt = {sreg[DW-2:0], ge};
                    r_nxt = ge ? diff : prem[VW-1:0];
`ifdef SEQ_DIV_DBZ_EN
                    dbz_nxt = 1'b0;
`endif
                end
            end
            default: ;
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            dsor <= '0;
            rem  <= '0;
            cnt  <= '0;
            q    <= '0;
            r    <= '0;
            busy <= 1'b0;
            done <= 1'b0;
`ifdef SEQ_DIV_DBZ_EN
            dbz  <= 1'b0;
`endif
        end else begin
            sreg <= sreg_nxt;
            dsor <= dsor_nxt;
            rem  <= rem_nxt;
            cnt  <= cnt_nxt;
            q    <= q_nxt;
            r    <= r_nxt;
            busy <= busy_nxt;
            done <= done_nxt;
`ifdef SEQ_DIV_DBZ_EN
            dbz  <= dbz_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div (DW=8, VW=4); build with +define+SEQ_DIV_DBZ_EN to cover dbz.
module tb_seq_div;

    localparam int LAT = 8;   // index of done cycle, acceptance edge counted as 0

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy, done;
    logic [7:0] q;
    logic [3:0] r;
`ifdef SEQ_DIV_DBZ_EN
    logic       dbz;
`endif

    int n_vec = 0;
    int n_err = 0;

    int         first_done, n_done, n_busy;
    logic [7:0] cap_q;
    logic [3:0] cap_r;
    logic       cap_dbz;

    seq_div #(.DW(8), .VW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r)
`ifdef SEQ_DIV_DBZ_EN
        ,
        .dbz      (dbz)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one op with a one-cycle start and record its timing and result over 15 cycles.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b);
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        first_done = -1;
        n_done     = 0;
        n_busy     = 0;
        cap_q      = 'x;
        cap_r      = 'x;
        cap_dbz    = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (i == 0) begin
                start    = 1'b0;
                dividend = ~a;
                divisor  = ~b;
            end
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = i;
                    cap_q      = q;
                    cap_r      = r;
`ifdef SEQ_DIV_DBZ_EN
                    cap_dbz    = dbz;
`endif
                end
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if ({busy, done, q, r} !== 14'h0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d expected all 0", busy, done, q, r);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_vec++;
            if ({busy, done, q, r} !== 14'h0) begin
                n_err++;
                $display("FAIL idle_cycle%0d: got busy=%b done=%b q=%0d r=%0d expected all 0", i, busy, done, q, r);
            end
        end
    endtask

    task automatic test_basic();
        run_op(8'd100, 4'd7);
        n_vec++;
        if (cap_q !== 8'd14 || cap_r !== 4'd2) begin
            n_err++;
            $display("FAIL basic_100_7: got q=%0d r=%0d expected q=14 r=2", cap_q, cap_r);
        end
        n_vec++;
        if (first_done !== LAT || n_done !== 1 || n_busy !== LAT + 1) begin
            n_err++;
            $display("FAIL basic_timing: got done_at=%0d done_cycles=%0d busy_cycles=%0d expected %0d 1 %0d",
                     first_done, n_done, n_busy, LAT, LAT + 1);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] ta [4] = '{8'd255, 8'd13, 8'd0, 8'd240};
        logic [3:0] tb [4] = '{4'd1, 4'd15, 4'd5, 4'd15};
        logic [7:0] eq [4] = '{8'd255, 8'd0, 8'd0, 8'd16};
        logic [3:0] er [4] = '{4'd0, 4'd13, 4'd0, 4'd0};
        for (int k = 0; k < 4; k++) begin
            run_op(ta[k], tb[k]);
            n_vec++;
            if (cap_q !== eq[k] || cap_r !== er[k]) begin
                n_err++;
                $display("FAIL bound_%0d_%0d: got q=%0d r=%0d expected q=%0d r=%0d",
                         ta[k], tb[k], cap_q, cap_r, eq[k], er[k]);
            end
            n_vec++;
            if (first_done !== LAT || n_done !== 1) begin
                n_err++;
                $display("FAIL bound_timing_%0d: got done_at=%0d done_cycles=%0d expected %0d 1",
                         k, first_done, n_done, LAT);
            end
        end
    endtask

    task automatic test_div_zero();
        run_op(8'hA7, 4'd0);
`ifdef SEQ_DIV_DBZ_EN
        n_vec++;
        if (cap_dbz !== 1'b1 || cap_q !== 8'h00 || cap_r !== 4'h0) begin
            n_err++;
            $display("FAIL dbz_result: got dbz=%b q=%h r=%h expected dbz=1 q=00 r=0", cap_dbz, cap_q, cap_r);
        end
        n_vec++;
        if (first_done !== 0 || n_done !== 1 || n_busy !== 1) begin
            n_err++;
            $display("FAIL dbz_timing: got done_at=%0d done_cycles=%0d busy_cycles=%0d expected 0 1 1",
                     first_done, n_done, n_busy);
        end
        run_op(8'd100, 4'd7);
        n_vec++;
        if (cap_dbz !== 1'b0 || cap_q !== 8'd14 || cap_r !== 4'd2) begin
            n_err++;
            $display("FAIL dbz_clear: got dbz=%b q=%0d r=%0d expected dbz=0 q=14 r=2", cap_dbz, cap_q, cap_r);
        end
`else
        n_vec++;
        if (cap_q !== 8'hFF || cap_r !== 4'h7) begin
            n_err++;
            $display("FAIL div0_result: got q=%h r=%h expected q=ff r=7", cap_q, cap_r);
        end
        n_vec++;
        if (first_done !== LAT || n_done !== 1) begin
            n_err++;
            $display("FAIL div0_timing: got done_at=%0d done_cycles=%0d expected %0d 1", first_done, n_done, LAT);
        end
`endif
    endtask

    task automatic test_ignore_start();
        dividend   = 8'd100;
        divisor    = 4'd7;
        start      = 1'b1;
        first_done = -1;
        n_done     = 0;
        n_busy     = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            start = (i == 3);
            if (i == 3) begin
                dividend = 8'd50;
                divisor  = 4'd6;
            end
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = i;
                    cap_q = q;
                    cap_r = r;
                end
            end
        end
        n_vec++;
        if (cap_q !== 8'd14 || cap_r !== 4'd2 || first_done !== LAT) begin
            n_err++;
            $display("FAIL ignore_start: got q=%0d r=%0d done_at=%0d expected q=14 r=2 done_at=%0d",
                     cap_q, cap_r, first_done, LAT);
        end
        n_vec++;
        if (n_done !== 1 || n_busy !== LAT + 1) begin
            n_err++;
            $display("FAIL ignore_extra_op: got done_cycles=%0d busy_cycles=%0d expected 1 %0d",
                     n_done, n_busy, LAT + 1);
        end
    endtask

    task automatic test_back_to_back();
        int         d_at [2];
        logic [7:0] dq [2];
        logic [3:0] dr [2];
        dividend = 8'd100;
        divisor  = 4'd7;
        start    = 1'b1;
        n_done   = 0;
        d_at     = '{-1, -1};
        for (int i = 0; i < 30; i++) begin
            step();
            if (i == 0) begin
                dividend = 8'd50;
                divisor  = 4'd6;
            end
            if (done) begin
                if (n_done < 2) begin
                    d_at[n_done] = i;
                    dq[n_done]   = q;
                    dr[n_done]   = r;
                end
                n_done++;
                if (n_done == 2) start = 1'b0;
            end
        end
        n_vec++;
        if (dq[0] !== 8'd14 || dr[0] !== 4'd2) begin
            n_err++;
            $display("FAIL b2b_first: got q=%0d r=%0d expected q=14 r=2", dq[0], dr[0]);
        end
        n_vec++;
        if (dq[1] !== 8'd8 || dr[1] !== 4'd2) begin
            n_err++;
            $display("FAIL b2b_second: got q=%0d r=%0d expected q=8 r=2", dq[1], dr[1]);
        end
        n_vec++;
        if (d_at[0] !== LAT || d_at[1] !== LAT + 10 || n_done !== 2) begin
            n_err++;
            $display("FAIL b2b_spacing: got done_at=%0d,%0d count=%0d expected %0d,%0d count=2",
                     d_at[0], d_at[1], n_done, LAT, LAT + 10);
        end
    endtask

    task automatic test_reset_mid();
        dividend = 8'd100;
        divisor  = 4'd7;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        #4;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, q, r} !== 14'h0) begin
            n_err++;
            $display("FAIL midop_reset: got busy=%b done=%b q=%0d r=%0d expected all 0", busy, done, q, r);
        end
        step();
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done || busy) n_done++;
        end
        n_vec++;
        if (n_done !== 0) begin
            n_err++;
            $display("FAIL midop_no_done: got %0d active cycles expected 0", n_done);
        end
        run_op(8'd50, 4'd6);
        n_vec++;
        if (cap_q !== 8'd8 || cap_r !== 4'd2 || first_done !== LAT) begin
            n_err++;
            $display("FAIL post_reset_50_6: got q=%0d r=%0d done_at=%0d expected q=8 r=2 done_at=%0d",
                     cap_q, cap_r, first_done, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
Sequential unsigned restoring divider, the inverse of the team's shift-add sequential multiplier. Accepts an N-bit dividend and M-bit divisor on a start pulse and produces one quotient bit per clock. Returns quotient and remainder with a done pulse. Sits beside the multiplier in the arithmetic datapath, e.g. to recover operands from products.

Parameters:
DW, 8, dividend and quotient width in bits (>=2)
VW, 4, divisor and remainder width in bits (>=1, <=DW)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in IDLE
dividend  input  DW  unsigned dividend, sampled with start
divisor  input  VW  unsigned divisor, sampled with start
busy  output  1  high from the cycle after start acceptance until return to IDLE
done  output  1  one-cycle pulse; q/r valid for the result just finished
q  output  DW  quotient, registered, held until next result
r  output  VW  remainder, registered, held until next result

Behaviour:
- Reset (rst async, active-high; clock clk): state=IDLE, busy=0, done=0, q=0, r=0, internal regs and counter 0. Reset mid-operation aborts the operation; no done is ever produced for it.
- States: IDLE, CALC, DONE; 2-bit state register; all outputs registered.
- IDLE: if start=1 at edge E0, latch dividend into shift reg, divisor into div reg, clear partial remainder (VW+1 bits) and counter -> CALC; busy=1 from E0. If start=0, stay.
- CALC, one iteration per edge E1..E_DW:
  - Shift {prem, dividend MSB} left by one into prem.
  - If prem >= {1'b0, div}: prem -= div; shift 1 into quotient LSB. Else shift 0.
  - Counter increments; at E_DW the counter reaches DW-1 -> DONE; q and r (prem[VW-1:0]) are written at that edge.
- DONE: done=1 for exactly that cycle, busy=1; next edge -> IDLE, done=0, busy=0.
- Latency: done high in cycle following edge E_DW, i.e. DW+1 edges after acceptance. Throughput: one op per DW+2 cycles.
- start while busy=1: ignored. start held high continuously: new op accepted on the first IDLE edge after DONE.
- Inputs dividend/divisor are don't-care after acceptance; changes mid-op do not affect the result.
- Width rules: prem is VW+1 bits so the compare never overflows. Quotient is DW bits, never truncated for divisor >= 1.
- Divisor 0 (macro off): algorithm runs unchanged. Every compare passes, giving q = all ones and r = dividend[VW-1:0], normal latency.

Optional Feature:
SEQ_DIV_DBZ_EN
- Defined: adds output port dbz (1 bit, reset 0). If divisor==0 at acceptance edge E0, go directly IDLE->DONE, skipping CALC. At E0 write q=0, r=0, dbz=1; done is high the cycle after E0. Any nonzero-divisor result writes dbz=0 with q/r.
- Undefined: no dbz port; divisor 0 handled as the natural result above.

Test Plan:
- Reset then idle, DW=8/VW=4: start=0 for 20 cycles -> busy=0, done=0, q=0, r=0 throughout.
- dividend=100, divisor=7, one-cycle start -> done exactly 9 edges after acceptance with q=14, r=2; busy high 9 cycles; done high 1 cycle.
- Boundaries: 255/1 -> q=255, r=0. 13/15 -> q=0, r=13. 0/5 -> q=0, r=0. 240/15 -> q=16, r=0.
- Divisor 0, dividend=8'hA7 -> macro off: q=8'hFF, r=4'h7 after 9 edges. Macro on: dbz=1, q=0, r=0, done 1 edge after acceptance. A following 100/7 yields dbz=0.
- start pulsed during CALC with different operands, and start held high -> mid-op starts ignored, first result unchanged. Held start yields back-to-back ops every 10 cycles.
- Assert rst at edge E4 of a 100/7 op -> outputs 0 immediately, no done. Post-reset 50/6 -> q=8, r=2.
